// File: rtl/proc_run_ctrl.sv
// Run controller for the pipelined RISC-V core.
// Sequences the core reset, counts RUN/DRAIN cycles and retired instructions,
// detects test end through a store to the tohost address, and reports
// pass / fail code / cycle-budget timeout once the run is finished.
// Optional build macro: RUN_CTRL_STALL_WDOG_EN adds a no-retire stall watchdog
// that ends the run with hang=1 after STALL_LIMIT consecutive idle RUN cycles.
module proc_run_ctrl #(
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned MAX_CYCLES   = 100,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0FFC,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned STALL_LIMIT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             retire_valid,
    input  logic             dmem_we,
    input  logic [31:0]      dmem_addr,
    input  logic [31:0]      dmem_wdata,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             hang,
    output logic [30:0]      fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam int unsigned RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned RST_LAST = RST_CYCLES - 1;
    localparam int unsigned DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned DRN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        st_idle,
        st_reset,
        st_run,
        st_drain,
        st_done
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [RST_W-1:0]  rst_cnt;
    logic [DRN_W-1:0]  drain_cnt;
    logic              cap_pass;
    logic [30:0]       cap_fail_code;

    logic              tohost_hit;
    logic              tohost_pass;
    logic              budget_hit;
    logic              pass_n;
    logic              timeout_n;
    logic              hang_n;
    logic [30:0]       fail_code_n;

    assign tohost_hit  = dmem_we && (dmem_addr == TOHOST_ADDR);
    assign tohost_pass = (dmem_wdata == 32'd1);
    assign budget_hit  = (cycle_count == CNT_W'(MAX_CYCLES - 1));

`ifdef RUN_CTRL_STALL_WDOG_EN
    localparam int unsigned STL_W    = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam int unsigned STL_LAST = (STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0;

    logic [STL_W-1:0] stall_cnt;
    logic             stall_hit;

    assign stall_hit = !retire_valid && (stall_cnt == STL_W'(STL_LAST));

    // Consecutive RUN cycles without a retire; idle outside RUN.
    always_ff @(posedge clk) begin
        if (rst || state != st_run || retire_valid) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + STL_W'(1);
        end
    end
`else
    logic [31:0] stall_limit_unused;
    assign stall_limit_unused = 32'(STALL_LIMIT);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_n;
        end
    end

    // Next state and the status to publish on entry to DONE (halt > timeout > hang).
    always_comb begin
        state_n     = state;
        pass_n      = 1'b0;
        timeout_n   = 1'b0;
        hang_n      = 1'b0;
        fail_code_n = '0;
        case (state)
            st_idle: begin
                if (start) begin
                    state_n = st_reset;
                end
            end
            st_reset: begin
                if (rst_cnt == RST_W'(RST_LAST)) begin
                    state_n = st_run;
                end
            end
            st_run: begin
                if (tohost_hit) begin
                    state_n     = (DRAIN_CYCLES == 0) ? st_done : st_drain;
                    pass_n      = tohost_pass;
                    fail_code_n = tohost_pass ? 31'd0 : dmem_wdata[31:1];
                end else if (budget_hit) begin
                    state_n   = st_done;
                    timeout_n = 1'b1;
                end
`ifdef RUN_CTRL_STALL_WDOG_EN
                else if (stall_hit) begin
                    state_n = st_done;
                    hang_n  = 1'b1;
                end
`endif
            end
            st_drain: begin
                if (drain_cnt == DRN_W'(DRN_LAST)) begin
                    state_n     = st_done;
                    pass_n      = cap_pass;
                    fail_code_n = cap_fail_code;
                end
            end
            default: begin
                if (start) begin
                    state_n = st_reset;
                end
            end
        endcase
    end

    // Registered outputs, phase counters, halt capture and run counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rst      <= 1'b1;
            running       <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            hang          <= 1'b0;
            fail_code     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
            rst_cnt       <= '0;
            drain_cnt     <= '0;
            cap_pass      <= 1'b0;
            cap_fail_code <= '0;
        end else begin
            core_rst  <= !(state_n == st_run || state_n == st_drain);
            running   <= (state_n == st_run || state_n == st_drain);
            done      <= (state_n == st_done);
            rst_cnt   <= (state == st_reset) ? rst_cnt + RST_W'(1) : '0;
            drain_cnt <= (state == st_drain) ? drain_cnt + DRN_W'(1) : '0;

            if (state == st_run && tohost_hit) begin
                cap_pass      <= tohost_pass;
                cap_fail_code <= tohost_pass ? 31'd0 : dmem_wdata[31:1];
            end

            if (state_n == st_reset) begin
                cycle_count   <= '0;
                instret_count <= '0;
            end else if (state == st_run || state == st_drain) begin
                if (cycle_count != '1) begin
                    cycle_count <= cycle_count + CNT_W'(1);
                end
                if (retire_valid && instret_count != '1) begin
                    instret_count <= instret_count + CNT_W'(1);
                end
            end

            if (state_n == st_reset) begin
                pass      <= 1'b0;
                timeout   <= 1'b0;
                hang      <= 1'b0;
                fail_code <= '0;
            end else if (state_n == st_done && state != st_done) begin
                pass      <= pass_n;
                timeout   <= timeout_n;
                hang      <= hang_n;
                fail_code <= fail_code_n;
            end
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: expected run results are queued when
// the halting (or non-halting) stimulus is applied and checked when done rises.
module tb_proc_run_ctrl;

    localparam logic [31:0] TOHOST = 32'h0000_0FFC;

    typedef struct {
        logic        pass;
        logic        tmo;
        logic        hang;
        logic [30:0] fc;
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        retire_valid;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        core_rst;
    logic        running;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        hang;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    int   n_vec = 0;
    int   n_err = 0;
    int   j     = 0;
    int   rmode = 1;
    int   n;
    int   lat;
    exp_t sb[$];

    always #5 clk = ~clk;

    proc_run_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .retire_valid  (retire_valid),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .core_rst      (core_rst),
        .running       (running),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .hang          (hang),
        .fail_code     (fail_code),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic t, input logic h,
                                input logic [30:0] f, input logic [31:0] c,
                                input logic [31:0] i);
        exp_t e;
        e.pass = p; e.tmo = t; e.hang = h; e.fc = f; e.cyc = c; e.ins = i;
        return e;
    endfunction

    function automatic logic rbit(input int jj);
        case (rmode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return (jj % 2) == 0;
        endcase
    endfunction

    // One RUN-relative cycle: drive this cycle's retire, advance to next negedge.
    task automatic step();
        retire_valid = rbit(j);
        @(negedge clk);
        j++;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        dmem_we    = 1'b1;
        dmem_addr  = addr;
        dmem_wdata = data;
        step();
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
    endtask

    // Pulse start, check cleared status during RESET, measure the reset length.
    task automatic start_run(output int nr);
        start        = 1'b1;
        retire_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("reset_done",    64'(done),          64'(0));
        chk("reset_pass",    64'(pass),          64'(0));
        chk("reset_timeout", 64'(timeout),       64'(0));
        chk("reset_cycles",  64'(cycle_count),   64'(0));
        chk("reset_instret", 64'(instret_count), 64'(0));
        nr = 0;
        while (core_rst === 1'b1 && nr < 50) begin
            nr++;
            @(negedge clk);
        end
        j = 0;
        chk("core_rst_len",  64'(nr),          64'(4));
        chk("run_cycle0",    64'(cycle_count), 64'(0));
        chk("run_running",   64'(running),     64'(1));
    endtask

    task automatic wait_done(input int bound, output int l);
        exp_t e;
        l = 0;
        while (done !== 1'b1 && l < bound) begin
            step();
            l++;
        end
        chk("done_seen",     64'(done),     64'(1));
        chk("done_core_rst", 64'(core_rst), 64'(1));
        chk("done_running",  64'(running),  64'(0));
        chk("sb_depth",      64'(sb.size()), 64'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pass",      64'(pass),          64'(e.pass));
            chk("timeout",   64'(timeout),       64'(e.tmo));
            chk("hang",      64'(hang),          64'(e.hang));
            chk("fail_code", 64'(fail_code),     64'(e.fc));
            chk("cycles",    64'(cycle_count),   64'(e.cyc));
            chk("instret",   64'(instret_count), 64'(e.ins));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (miscompares so far %0d)", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        retire_valid = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        repeat (3) @(negedge clk);
        chk("por_core_rst",  64'(core_rst),      64'(1));
        chk("por_running",   64'(running),       64'(0));
        chk("por_done",      64'(done),          64'(0));
        chk("por_cycles",    64'(cycle_count),   64'(0));
        chk("por_instret",   64'(instret_count), 64'(0));
        chk("por_status",    64'({pass, timeout, hang, fail_code}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Pass at RUN cycle 20, retire every cycle.
        start_run(n);
        rmode = 1;
        repeat (20) step();
        chk("t1_cyc_at_store", 64'(cycle_count), 64'(20));
        chk("t1_status_pre",   64'(pass),        64'(0));
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 31'd0, 32'd24, 32'd24));
        store(TOHOST, 32'd1);
        wait_done(200, lat);
        chk("t1_halt_latency", 64'(lat + 1), 64'(4));
        repeat (2) step();
        chk("t1_hold_done",   64'(done),        64'(1));
        chk("t1_hold_cycles", 64'(cycle_count), 64'(24));

        // Failure code, alternating retires.
        start_run(n);
        rmode = 2;
        repeat (5) step();
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 31'd3, 32'd9, 32'd5));
        store(TOHOST, 32'h0000_0007);
        wait_done(200, lat);

        // Timeout after the full budget.
        start_run(n);
        rmode = 1;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 31'd0, 32'd100, 32'd100));
        wait_done(300, lat);
        chk("t3_timeout_cycles", 64'(lat), 64'(100));

        // Halt coincides with last budget cycle; stray stores ignored.
        start_run(n);
        rmode = 1;
        repeat (10) step();
        store(32'h0000_0FF8, 32'd1);
        repeat (88) step();
        chk("t4_cyc_99", 64'(cycle_count), 64'(99));
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 31'd0, 32'd103, 32'd103));
        store(TOHOST, 32'd1);
        chk("t4_drain_running", 64'(running), 64'(1));
        store(TOHOST, 32'd5);
        wait_done(200, lat);

        // start ignored in RUN; rst aborts mid-run.
        start_run(n);
        rmode = 1;
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_start_ign_run",  64'(running),     64'(1));
        chk("t5_start_ign_crst", 64'(core_rst),    64'(0));
        chk("t5_start_ign_cyc",  64'(cycle_count), 64'(6));
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_abort_core_rst", 64'(core_rst),      64'(1));
        chk("t5_abort_running",  64'(running),       64'(0));
        chk("t5_abort_cycles",   64'(cycle_count),   64'(0));
        chk("t5_abort_instret",  64'(instret_count), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_idle_core_rst", 64'(core_rst), 64'(1));
        chk("t5_idle_done",     64'(done),     64'(0));

        // No retires at all.
        start_run(n);
        rmode = 0;
`ifdef RUN_CTRL_STALL_WDOG_EN
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 31'd0, 32'd16, 32'd0));
`else
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 31'd0, 32'd100, 32'd0));
`endif
        wait_done(300, lat);

        chk("sb_leftover", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
Synthesizable run controller for the pipelined RISC-V core. It sequences the core reset with a parametrised length, counts cycles and retired instructions, and detects test completion through a tohost store. It also enforces a cycle-budget timeout and reports pass, fail or timeout status. It sits between the top-level clk/rst and the processor, replacing fixed-delay reset and timeout sequencing with a programmable, observable block.

Parameters:
RST_CYCLES, 4, cycles core_rst is held high after entering RESET (>=1)
MAX_CYCLES, 100, RUN cycle budget before timeout (>=1)
DRAIN_CYCLES, 3, cycles waited after halt detect before DONE (pipeline depth; 0 allowed)
TOHOST_ADDR, 32'h0000_0FFC, data-memory address whose store signals test end
CNT_W, 32, width of cycle and instret counters
STALL_LIMIT, 16, max consecutive RUN cycles without retire (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a reset+run sequence
retire_valid  in  1  core retired one instruction this cycle
dmem_we  in  1  core data-memory write enable
dmem_addr  in  32  core data-memory address
dmem_wdata  in  32  core data-memory write data
core_rst  out  1  reset to processor
running  out  1  high in RUN and DRAIN
done  out  1  high in DONE
pass  out  1  valid when done
timeout  out  1  valid when done
hang  out  1  valid when done (0 if optional feature is absent)
fail_code  out  31  tohost value >>1 on failure, else 0
cycle_count  out  CNT_W  RUN+DRAIN cycles elapsed
instret_count  out  CNT_W  retired instructions

Behaviour:
- Reset (rst=1, synchronous): state=IDLE, core_rst=1, all counters and status outputs 0. rst overrides every other input and aborts any in-progress sequence immediately.
- States: IDLE, RESET, RUN, DRAIN, DONE.
- IDLE: core_rst=1. start=1 -> RESET on the next edge; the rst counter loads 0.
- RESET: core_rst=1 for exactly RST_CYCLES cycles, then -> RUN. cycle_count, instret_count and status are cleared on entry.
- RUN: core_rst=0, running=1. cycle_count +1 per cycle. instret_count +1 when retire_valid is high.
- Halt: dmem_we=1 and dmem_addr==TOHOST_ADDR in RUN. Capture dmem_wdata. If wdata==1: pass=1 at DONE, fail_code=0. Otherwise pass=0, fail_code=wdata[31:1]. Then -> DRAIN, or -> DONE directly if DRAIN_CYCLES=0.
- Timeout: in RUN, when cycle_count==MAX_CYCLES-1 and no halt in that cycle -> DONE with timeout=1, pass=0. If halt and timeout coincide in the same cycle, halt wins.
- DRAIN: core_rst=0. Counters keep counting, including retires. Further tohost stores are ignored. After DRAIN_CYCLES cycles -> DONE.
- DONE: core_rst=1 (core frozen), done=1. Counters and status hold. start=1 -> RESET, beginning a new run with status cleared. start in any state other than IDLE/DONE is ignored.
- Counters saturate at all-ones and do not wrap.
- Status outputs (pass, timeout, hang, fail_code) are registered and read 0 until DONE. Latency from the halt store to done is DRAIN_CYCLES+1 cycles.

Optional Feature:
RUN_CTRL_STALL_WDOG_EN
- Defined: a stall counter clears on retire_valid and increments on each RUN cycle without a retire. Reaching STALL_LIMIT -> DONE with hang=1, pass=0. Priority order: halt > timeout > hang.
- Undefined: no stall counter is synthesized; hang is tied 0.

Test Plan:
- rst=1 then 0, start pulse, core retires every cycle, store 1 to 0xFFC at RUN cycle 20 -> core_rst high for exactly 4 cycles; done 4 cycles after the store; pass=1, fail_code=0, instret_count=cycle_count=24.
- Store 0x0000_0007 to 0xFFC -> done=1, pass=0, fail_code=3, timeout=0.
- No tohost store -> done asserted after cycle_count=100, timeout=1, pass=0; second start -> RESET, status cleared, cycle_count restarts from 0.
- Halt store and cycle 99 in the same cycle -> pass=1, timeout=0. A store to 0xFF8 is ignored. A second tohost store during DRAIN (value 5) is ignored; pass remains 1.
- rst asserted mid-RUN at cycle 10 -> next cycle state IDLE, core_rst=1, counters=0. start while in RUN has no effect.
- With RUN_CTRL_STALL_WDOG_EN: retire_valid held 0 in RUN -> done after 16 cycles with hang=1. Without the macro, same stimulus -> timeout=1 at 100, hang=0.
